// File: rtl/demux_stream_if.sv
// demux_stream_if: bundles the producer-side valid/ready bus and the
// per-channel output bus of demux_stream.
//   master : drives in_valid/in_data/in_sel/in_bcast and out_ready, observes the rest
//   slave  : the demultiplexer itself
interface demux_stream_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_bcast;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [N*WIDTH-1:0] out_data;
  logic               err;
  logic [7:0]         drop_cnt;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err, drop_cnt
  );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: 1:N streaming demultiplexer. Each word on the input
// valid/ready port is routed to channel in_sel, or to every channel when
// in_bcast=1. Each channel is a one-entry output register with its own
// back-pressure. Unicast words with an out-of-range select are accepted and
// dropped, pulsing err and bumping a saturating 8-bit drop counter.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : demux_stream_if.slave (input handshake, per-channel outputs,
//           err pulse, drop_cnt)
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input logic           clk,
  input logic           rst_n,
  demux_stream_if.slave bus
);

  logic [N-1:0]     valid_reg;
  logic [WIDTH-1:0] data_reg [N];
  logic [N-1:0]     free;
  logic [N-1:0]     load;
  logic             sel_hit;
  logic             sel_free;
  logic             xfer;
  logic             drop;
  logic             err_reg;
  logic [7:0]       drop_cnt_reg;

  // Looking up the selected channel by comparison rather than by indexing
  // keeps out-of-range selects (N not a power of two) from ever addressing
  // a non-existent channel.
  always_comb begin
    sel_hit  = 1'b0;
    sel_free = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (int'(bus.in_sel) == c) begin
        sel_hit  = 1'b1;
        sel_free = free[c];
      end
    end
  end

  // Broadcast is all-or-nothing; out-of-range words are always taken.
  always_comb begin
    if (bus.in_bcast)
      bus.in_ready = &free;
    else if (sel_hit)
      bus.in_ready = sel_free;
    else
      bus.in_ready = 1'b1;
  end

  assign xfer = bus.in_valid && bus.in_ready;
  assign drop = xfer && !bus.in_bcast && !sel_hit;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      // A channel is free when empty or being drained on this edge.
      assign free[gi] = !valid_reg[gi] || bus.out_ready[gi];
      assign load[gi] = xfer && (bus.in_bcast || (sel_hit && int'(bus.in_sel) == gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
        end else if (load[gi]) begin
          // Also covers drain-and-reload on the same edge.
          valid_reg[gi] <= 1'b1;
          data_reg[gi]  <= bus.in_data;
        end else if (bus.out_ready[gi]) begin
          valid_reg[gi] <= 1'b0;
        end
      end

      assign bus.out_data[gi*WIDTH +: WIDTH] = data_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg      <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      err_reg <= drop;
      if (drop && drop_cnt_reg != 8'hFF)
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign bus.out_valid = valid_reg;
  assign bus.err       = err_reg;
  assign bus.drop_cnt  = drop_cnt_reg;

endmodule
